regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
Owns the single write port of Register_File and shares it between two writeback requesters: the ALU/execute path and the load/store unit (LSU). After reset it sequences a zero-initialisation sweep of x1..x31. It then grants write requests with round-robin fairness over a valid/ready handshake, driving the register file's write_enable, write_reg and write_data from registered outputs.

Parameters:
NUM_REGS, 32, architectural register count; x0 is never written.
ADDR_WIDTH, 5, register index width; must equal clog2(NUM_REGS).
DATA_WIDTH, 32, register data width.
INIT_ON_RESET, 1, 1 = run the zeroing sweep after reset; 0 = go straight to RUN.

Ports:
pll_1_200MHz  in   1           system clock; all logic on posedge
reset         in   1           synchronous, active-high reset
alu_valid     in   1           ALU writeback request
alu_ready     out  1           ALU request accepted this cycle
alu_rd        in   ADDR_WIDTH  ALU destination register
alu_data      in   DATA_WIDTH  ALU result
lsu_valid     in   1           LSU load-writeback request
lsu_ready     out  1           LSU request accepted this cycle
lsu_rd        in   ADDR_WIDTH  LSU destination register
lsu_data      in   DATA_WIDTH  load data
write_enable  out  1           to Register_File.write_enable
write_reg     out  ADDR_WIDTH  to Register_File.write_reg
write_data    out  DATA_WIDTH  to Register_File.write_data
write_src     out  1           source of current write: 0 = ALU, 1 = LSU
init_busy     out  1           high while the zeroing sweep runs

Behaviour:
- Reset (sampled at posedge): state = INIT if INIT_ON_RESET, else RUN. init_cnt = 1. last_grant = ALU, so the LSU wins the first tie. Outputs: write_enable = 0, write_reg = 0, write_data = 0, write_src = 0, init_busy = INIT_ON_RESET.
- Reset mid-operation: any sweep or accepted request is abandoned. The sweep restarts at x1. In-flight requests are not accepted; requesters hold valid.
- INIT:
  - Each edge drives write_enable = 1, write_reg = init_cnt, write_data = 0, then increments init_cnt.
  - First edge after reset release writes x1. The 31st edge writes x31.
  - The 32nd edge drives write_enable = 0 and init_busy = 0, and moves to RUN.
  - alu_ready and lsu_ready are 0 throughout INIT.
- RUN, ready generation (combinational from valid and last_grant):
  - One valid: that requester gets ready = 1.
  - Both valid: the requester that is not last_grant gets ready = 1.
  - At most one ready is high per cycle.
  - Requesters must not make valid depend on ready, and must hold rd/data stable while valid && !ready.
- Handshake (valid && ready at posedge):
  - write_enable <= (rd != 0), write_reg <= rd, write_data <= data, write_src <= source.
  - last_grant <= source.
  - Latency: register-file write lands on the edge after the handshake edge, i.e. 1-cycle writeback latency.
- No handshake: write_enable <= 0. write_reg, write_data and write_src hold their values.
- x0 target: the handshake completes and last_grant updates, but write_enable stays 0.
- Both requesters target the same rd in the same cycle: only the winner is written. The loser is written the following cycle, so the final value is the later-granted data.
- Sustained contention: grants strictly alternate, one write per cycle, with no bubbles.

Decomposition:
- Shared package/header rv32i_pkg:
  - ADDR_WIDTH and DATA_WIDTH constants
  - state encoding ST_INIT / ST_RUN
  - source encoding SRC_ALU = 0, SRC_LSU = 1
- One natural sub-module, rr_arbiter2: a 2-way round-robin grant from (req[1:0], last_grant) to one-hot grant. It is purely combinational; the last_grant flop stays in the parent.

Test Plan:
1. Assert reset 2 cycles, then release -> 31 consecutive writes to x1..x31 with data 0; init_busy falls on edge 32; alu_ready/lsu_ready = 0 throughout.
2. After init: alu_valid = 1, alu_rd = 5, alu_data = 0xFFFFFFFF for one cycle -> alu_ready = 1 that cycle; next edge write_enable = 1, write_reg = 5, write_data = 0xFFFFFFFF, write_src = 0; Register_File read of x5 returns 0xFFFFFFFF.
3. Both valid continuously: ALU rd = 3, data 0x11111111; LSU rd = 4, data 0x22222222 -> grants LSU, ALU, LSU, ALU...; write_src toggles 1, 0, 1, 0 every cycle.
4. lsu_valid with rd = 0, data 0xDEADBEEF -> lsu_ready = 1; write_enable remains 0; next ALU/LSU tie goes to ALU.
5. Same-target conflict: both rd = 7, ALU 0xAAAA0000, LSU 0x5555FFFF, after reset -> x7 written with 0x5555FFFF, then 0xAAAA0000; final x7 = 0xAAAA0000.
6. Assert reset for 1 cycle during a RUN stream with alu_valid held -> write_enable = 0 on the reset edge; sweep restarts at x1; alu_ready stays 0 until init_busy falls, then the held request is accepted.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I writeback constants: register-file geometry, arbiter state
// encoding and the writeback source encoding.
package rv32i_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester that was not granted
// last wins. Purely combinational; the last-grant flop lives in the parent.
module rr_arbiter2
  import rv32i_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == SRC_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: zeroes x1..x(NUM_REGS-1) after reset,
// then shares the port between ALU and LSU writeback with round-robin fairness.
module regfile_write_arbiter
  import rv32i_pkg::*;
#(
  parameter int NUM_REGS      = 32,
  parameter int ADDR_WIDTH    = rv32i_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH    = rv32i_pkg::DATA_WIDTH,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                  pll_1_200MHz,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_src,
  output logic                  init_busy
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  state_t                state_p0, state_nxt;
  logic [CNT_W-1:0]      init_cnt_p0, init_cnt_nxt;
  src_t                  last_grant_p0, last_grant_nxt;
  logic                  vld_p1, vld_nxt;
  logic [ADDR_WIDTH-1:0] reg_p1, reg_nxt;
  logic [DATA_WIDTH-1:0] data_p1, data_nxt;
  src_t                  src_p1, src_nxt;
  logic                  busy_p1, busy_nxt;
  logic [1:0]            gnt;
  logic                  run;

  rr_arbiter2 u_rr (
    .req        ({lsu_valid, alu_valid}),
    .last_grant (last_grant_p0),
    .gnt        (gnt)
  );

  // Readies are suppressed outside RUN so no request is accepted mid-sweep.
  assign run       = (state_p0 == ST_RUN);
  assign alu_ready = run & gnt[0];
  assign lsu_ready = run & gnt[1];

  always_comb begin
    state_nxt      = state_p0;
    init_cnt_nxt   = init_cnt_p0;
    last_grant_nxt = last_grant_p0;
    vld_nxt        = 1'b0;
    reg_nxt        = reg_p1;
    data_nxt       = data_p1;
    src_nxt        = src_p1;
    busy_nxt       = busy_p1;
    case (state_p0)
      ST_INIT: begin
        if (init_cnt_p0 == CNT_W'(NUM_REGS)) begin
          state_nxt = ST_RUN;
          busy_nxt  = 1'b0;
        end else begin
          vld_nxt      = 1'b1;
          reg_nxt      = init_cnt_p0[ADDR_WIDTH-1:0];
          data_nxt     = '0;
          init_cnt_nxt = init_cnt_p0 + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // x0 targets complete the handshake but never assert the write.
        if (alu_ready) begin
          vld_nxt        = (alu_rd != '0);
          reg_nxt        = alu_rd;
          data_nxt       = alu_data;
          src_nxt        = SRC_ALU;
          last_grant_nxt = SRC_ALU;
        end else if (lsu_ready) begin
          vld_nxt        = (lsu_rd != '0);
          reg_nxt        = lsu_rd;
          data_nxt       = lsu_data;
          src_nxt        = SRC_LSU;
          last_grant_nxt = SRC_LSU;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Stage p0 -> p1: control state and the registered write-port outputs.
  always_ff @(posedge pll_1_200MHz) begin
    if (reset) begin
      state_p0      <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      init_cnt_p0   <= CNT_W'(1);
      last_grant_p0 <= SRC_ALU;
      vld_p1        <= 1'b0;
      reg_p1        <= '0;
      data_p1       <= '0;
      src_p1        <= SRC_ALU;
      busy_p1       <= INIT_ON_RESET;
    end else begin
      state_p0      <= state_nxt;
      init_cnt_p0   <= init_cnt_nxt;
      last_grant_p0 <= last_grant_nxt;
      vld_p1        <= vld_nxt;
      reg_p1        <= reg_nxt;
      data_p1       <= data_nxt;
      src_p1        <= src_nxt;
      busy_p1       <= busy_nxt;
    end
  end

  assign write_enable = vld_p1;
  assign write_reg    = reg_p1;
  assign write_data   = data_p1;
  assign write_src    = src_p1;
  assign init_busy    = busy_p1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a shadow register file that
// commits whatever the write port drives.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, lsu_valid;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_data;
  logic        write_enable, write_src, init_busy;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] rf [32];

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter dut (
    .pll_1_200MHz (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .write_src    (write_src),
    .init_busy    (init_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_enable) rf[write_reg] <= write_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_init_done(input bit check_ready);
    for (int n = 0; n < 40 && init_busy; n++) begin
      if (check_ready) check("ready_in_init", {30'd0, lsu_ready, alu_ready}, 32'd0);
      step();
    end
    check("init_done", {31'd0, init_busy}, 32'd0);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = 32'hCAFE_0000 + r;
    reset = 1'b1;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    alu_rd = '0; lsu_rd = '0; alu_data = '0; lsu_data = '0;
    @(negedge clk);
    step();
    step();
    check("rst_we",   {31'd0, write_enable}, 32'd0);
    check("rst_reg",  {27'd0, write_reg}, 32'd0);
    check("rst_data", write_data, 32'd0);
    check("rst_src",  {31'd0, write_src}, 32'd0);
    check("rst_busy", {31'd0, init_busy}, 32'd1);

    // 1: sweep with both requesters waiting (they must not be accepted)
    reset = 1'b0;
    alu_valid = 1'b1; lsu_valid = 1'b1; alu_rd = 5'd9; lsu_rd = 5'd10;
    alu_data = 32'h0BAD_0001; lsu_data = 32'h0BAD_0002;
    for (int i = 1; i <= 31; i++) begin
      check("init_ready", {30'd0, lsu_ready, alu_ready}, 32'd0);
      step();
      check("init_we",   {31'd0, write_enable}, 32'd1);
      check("init_reg",  {27'd0, write_reg}, i);
      check("init_data", write_data, 32'd0);
      check("init_busy", {31'd0, init_busy}, 32'd1);
    end
    check("init_ready31", {30'd0, lsu_ready, alu_ready}, 32'd0);
    step();
    check("init_end_we",   {31'd0, write_enable}, 32'd0);
    check("init_end_busy", {31'd0, init_busy}, 32'd0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    check("rf_x9_zero",  rf[9], 32'd0);
    check("rf_x31_zero", rf[31], 32'd0);
    check("rf_x0_untouched", rf[0], 32'hCAFE_0000);

    // 2: single ALU write to x5
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hFFFF_FFFF;
    #1;
    check("t2_ready", {30'd0, lsu_ready, alu_ready}, 32'd1);
    step();
    alu_valid = 1'b0;
    check("t2_we",   {31'd0, write_enable}, 32'd1);
    check("t2_reg",  {27'd0, write_reg}, 32'd5);
    check("t2_data", write_data, 32'hFFFF_FFFF);
    check("t2_src",  {31'd0, write_src}, 32'd0);
    step();
    check("t2_we_drop", {31'd0, write_enable}, 32'd0);
    check("t2_hold_data", write_data, 32'hFFFF_FFFF);
    check("t2_rf_x5", rf[5], 32'hFFFF_FFFF);

    // 3: sustained contention, last grant was ALU so LSU leads
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1111_1111;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h2222_2222;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t3_ready", {30'd0, lsu_ready, alu_ready}, (k % 2 == 0) ? 32'd2 : 32'd1);
      step();
      check("t3_we",   {31'd0, write_enable}, 32'd1);
      check("t3_src",  {31'd0, write_src}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("t3_reg",  {27'd0, write_reg}, (k % 2 == 0) ? 32'd4 : 32'd3);
      check("t3_data", write_data, (k % 2 == 0) ? 32'h2222_2222 : 32'h1111_1111);
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;

    // 4: LSU write to x0 is accepted but suppressed, then ALU wins the tie
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hDEAD_BEEF;
    #1;
    check("t4_ready", {30'd0, lsu_ready, alu_ready}, 32'd2);
    step();
    lsu_valid = 1'b0;
    check("t4_we",  {31'd0, write_enable}, 32'd0);
    check("t4_src", {31'd0, write_src}, 32'd1);
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1234_5678;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h8765_4321;
    #1;
    check("t4_tie", {30'd0, lsu_ready, alu_ready}, 32'd1);
    step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    check("t4_tie_src",  {31'd0, write_src}, 32'd0);
    check("t4_tie_data", write_data, 32'h1234_5678);
    check("t4_rf_x0", rf[0], 32'hCAFE_0000);

    // 5: same-target conflict right after a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_init_done(1'b0);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hAAAA_0000;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h5555_FFFF;
    #1;
    check("t5_ready1", {30'd0, lsu_ready, alu_ready}, 32'd2);
    step();
    lsu_valid = 1'b0;
    check("t5_data1", write_data, 32'h5555_FFFF);
    check("t5_src1",  {31'd0, write_src}, 32'd1);
    #1;
    check("t5_ready2", {30'd0, lsu_ready, alu_ready}, 32'd1);
    step();
    alu_valid = 1'b0;
    check("t5_data2", write_data, 32'hAAAA_0000);
    check("t5_rf_mid", rf[7], 32'h5555_FFFF);
    step();
    check("t5_rf_x7", rf[7], 32'hAAAA_0000);

    // 6: reset during an ALU stream, held request accepted after the sweep
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0009;
    step();
    check("t6_stream_we", {31'd0, write_enable}, 32'd1);
    reset = 1'b1;
    step();
    check("t6_rst_we",    {31'd0, write_enable}, 32'd0);
    check("t6_rst_busy",  {31'd0, init_busy}, 32'd1);
    check("t6_rst_ready", {31'd0, alu_ready}, 32'd0);
    reset = 1'b0;
    step();
    check("t6_restart_reg", {27'd0, write_reg}, 32'd1);
    check("t6_restart_we",  {31'd0, write_enable}, 32'd1);
    wait_init_done(1'b1);
    #1;
    check("t6_accept_ready", {31'd0, alu_ready}, 32'd1);
    step();
    alu_valid = 1'b0;
    check("t6_we",   {31'd0, write_enable}, 32'd1);
    check("t6_reg",  {27'd0, write_reg}, 32'd9);
    check("t6_data", write_data, 32'h0000_0009);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
